// File: rtl/dispatch_router.sv
// dispatch_router: dispatches up to two in-order instructions per cycle to the ALU/LSU/BRU reservation
// stations under credit flow control; define DISPATCH_STATS_EN to build the performance counters.
module dispatch_router #(
  parameter int NUM_RS_ENTRIES = 8,
  parameter int ROB_WIDTH      = 4,
  parameter int INSTR_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] in_instruction_0,
  input  logic [INSTR_WIDTH-1:0] in_instruction_1,
  input  logic                   in_valid_0,
  input  logic                   in_valid_1,
  input  logic [ROB_WIDTH-1:0]   in_rob_id_0,
  input  logic [ROB_WIDTH-1:0]   in_rob_id_1,
  input  logic [ROB_WIDTH:0]     rob_free,
  output logic                   in_ready_0,
  output logic                   in_ready_1,
  input  logic                   alu_issue_valid,
  input  logic                   lsu_issue_valid,
  input  logic                   bru_issue_valid,
  output logic [INSTR_WIDTH-1:0] alu_dispatch_instruction_0,
  output logic [INSTR_WIDTH-1:0] alu_dispatch_instruction_1,
  output logic [ROB_WIDTH-1:0]   alu_rob_id_0,
  output logic [ROB_WIDTH-1:0]   alu_rob_id_1,
  output logic                   alu_dispatch_valid_0,
  output logic                   alu_dispatch_valid_1,
  output logic [INSTR_WIDTH-1:0] lsu_dispatch_instruction_0,
  output logic [INSTR_WIDTH-1:0] lsu_dispatch_instruction_1,
  output logic [ROB_WIDTH-1:0]   lsu_rob_id_0,
  output logic [ROB_WIDTH-1:0]   lsu_rob_id_1,
  output logic                   lsu_dispatch_valid_0,
  output logic                   lsu_dispatch_valid_1,
  output logic [INSTR_WIDTH-1:0] bru_dispatch_instruction_0,
  output logic [INSTR_WIDTH-1:0] bru_dispatch_instruction_1,
  output logic [ROB_WIDTH-1:0]   bru_rob_id_0,
  output logic [ROB_WIDTH-1:0]   bru_rob_id_1,
  output logic                   bru_dispatch_valid_0,
  output logic                   bru_dispatch_valid_1,
  output logic                   illegal_valid,
  output logic [31:0]            stat_dispatched,
  output logic [31:0]            stat_stall_cycles
);
  localparam int CW = NUM_RS_ENTRIES + 1;
  localparam logic [CW-1:0] FULL = CW'(NUM_RS_ENTRIES);
  localparam logic [1:0] CLS_ALU = 2'd0, CLS_LSU = 2'd1, CLS_BRU = 2'd2, CLS_ILL = 2'd3;
  localparam logic [6:0] OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_BRANCH = 7'h63, OPC_JAL = 7'h6f,
                         OPC_JALR = 7'h67, OPC_OP = 7'h33, OPC_OP_IMM = 7'h13, OPC_LUI = 7'h37,
                         OPC_AUIPC = 7'h17, OPC_SYSTEM = 7'h73;

  function automatic logic [1:0] f_class(input logic [6:0] op);
    return (op == OPC_LOAD || op == OPC_STORE) ? CLS_LSU :
           (op == OPC_BRANCH || op == OPC_JAL || op == OPC_JALR) ? CLS_BRU :
           (op == OPC_OP || op == OPC_OP_IMM || op == OPC_LUI || op == OPC_AUIPC ||
            op == OPC_SYSTEM) ? CLS_ALU : CLS_ILL;
  endfunction

  logic [1:0]         w_cls0, w_cls1;
  logic               w_ill0, w_ill1, w_rdy0, w_rdy1;
  logic [3:0][CW-1:0] w_credit;
  logic [CW-1:0]      w_cr0, w_cr1;
  logic [2:0]         w_iss;
  logic [2:0]         r_v0, r_v1;
  logic               r_ill;
  logic [INSTR_WIDTH-1:0] r_ins0, r_ins1;
  logic [ROB_WIDTH-1:0]   r_rob0, r_rob1;

  assign w_cls0 = f_class(in_instruction_0[6:0]);
  assign w_cls1 = f_class(in_instruction_1[6:0]);
  assign w_ill0 = w_cls0 == CLS_ILL;
  assign w_ill1 = w_cls1 == CLS_ILL;
  assign w_iss  = {bru_issue_valid, lsu_issue_valid, alu_issue_valid};
  assign w_credit[3] = '0;
  assign w_cr0  = w_credit[w_cls0];
  assign w_cr1  = w_credit[w_cls1];
  // Ready looks only at registered credits; issue returns land next cycle.
  assign w_rdy0 = !flush && in_valid_0 && rob_free != '0 && (w_ill0 || w_cr0 != '0);
  assign w_rdy1 = w_rdy0 && in_valid_1 && rob_free >= (ROB_WIDTH+1)'(2) &&
                  (w_ill1 || (w_cls1 == w_cls0 ? w_cr1 >= CW'(2) : w_cr1 != '0));
  assign in_ready_0 = w_rdy0;
  assign in_ready_1 = w_rdy1;

  for (genvar c = 0; c < 3; c++) begin : g_rs
    logic [CW-1:0] r_credit;
    logic [1:0]    w_use;
    assign w_use = 2'(w_rdy0 && w_cls0 == 2'(c)) + 2'(w_rdy1 && w_cls1 == 2'(c));
    assign w_credit[c] = r_credit;
    always_ff @(posedge clk or negedge rst)
      if (!rst) r_credit <= FULL;
      else r_credit <= flush ? FULL : r_credit + CW'(w_iss[c]) - CW'(w_use);
    a_credit_range: assert property (@(posedge clk) disable iff (!rst) r_credit <= FULL);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_v0  <= '0;
      r_v1  <= '0;
      r_ill <= 1'b0;
    end else begin
      r_v0  <= (w_rdy0 && !w_ill0) ? 3'b001 << w_cls0 : 3'b000;
      r_v1  <= (w_rdy1 && !w_ill1) ? 3'b001 << w_cls1 : 3'b000;
      r_ill <= (w_rdy0 && w_ill0) || (w_rdy1 && w_ill1);
    end

  // Payload is shared by all three RSs; only the valids steer it.
  always_ff @(posedge clk) begin
    r_ins0 <= in_instruction_0;
    r_ins1 <= in_instruction_1;
    r_rob0 <= in_rob_id_0;
    r_rob1 <= in_rob_id_1;
  end

  assign {bru_dispatch_valid_0, lsu_dispatch_valid_0, alu_dispatch_valid_0} = r_v0;
  assign {bru_dispatch_valid_1, lsu_dispatch_valid_1, alu_dispatch_valid_1} = r_v1;
  assign alu_dispatch_instruction_0 = r_ins0;
  assign lsu_dispatch_instruction_0 = r_ins0;
  assign bru_dispatch_instruction_0 = r_ins0;
  assign alu_dispatch_instruction_1 = r_ins1;
  assign lsu_dispatch_instruction_1 = r_ins1;
  assign bru_dispatch_instruction_1 = r_ins1;
  assign alu_rob_id_0 = r_rob0;
  assign lsu_rob_id_0 = r_rob0;
  assign bru_rob_id_0 = r_rob0;
  assign alu_rob_id_1 = r_rob1;
  assign lsu_rob_id_1 = r_rob1;
  assign bru_rob_id_1 = r_rob1;
  assign illegal_valid = r_ill;

`ifdef DISPATCH_STATS_EN
  logic [31:0] r_disp, r_stall;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_disp  <= '0;
      r_stall <= '0;
    end else begin
      r_disp  <= r_disp + 32'(w_rdy0) + 32'(w_rdy1);
      r_stall <= r_stall + 32'(in_valid_0 && !w_rdy0);
    end
  assign stat_dispatched   = r_disp;
  assign stat_stall_cycles = r_stall;
`else
  assign stat_dispatched   = '0;
  assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_dispatch_router.sv
// tb_dispatch_router: directed scenarios plus randomized traffic checked against a credit/queue model.
module tb_dispatch_router;
  localparam int N = 8, RW = 4, IW = 32;
  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63, JAL = 7'h6f, JALR = 7'h67,
                         OP = 7'h33, OPI = 7'h13, LUI = 7'h37, AUIPC = 7'h17, SYS = 7'h73,
                         BAD0 = 7'h7f, BAD1 = 7'h0f;
`ifdef DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, rst, flush;
  logic [IW-1:0] in_instruction_0, in_instruction_1;
  logic in_valid_0, in_valid_1, in_ready_0, in_ready_1;
  logic [RW-1:0] in_rob_id_0, in_rob_id_1;
  logic [RW:0] rob_free;
  logic alu_issue_valid, lsu_issue_valid, bru_issue_valid;
  logic [IW-1:0] alu_dispatch_instruction_0, alu_dispatch_instruction_1;
  logic [IW-1:0] lsu_dispatch_instruction_0, lsu_dispatch_instruction_1;
  logic [IW-1:0] bru_dispatch_instruction_0, bru_dispatch_instruction_1;
  logic [RW-1:0] alu_rob_id_0, alu_rob_id_1, lsu_rob_id_0, lsu_rob_id_1, bru_rob_id_0, bru_rob_id_1;
  logic alu_dispatch_valid_0, alu_dispatch_valid_1, lsu_dispatch_valid_0, lsu_dispatch_valid_1;
  logic bru_dispatch_valid_0, bru_dispatch_valid_1, illegal_valid;
  logic [31:0] stat_dispatched, stat_stall_cycles;

  dispatch_router #(.NUM_RS_ENTRIES(N), .ROB_WIDTH(RW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_instruction_0(in_instruction_0), .in_instruction_1(in_instruction_1),
    .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
    .in_rob_id_0(in_rob_id_0), .in_rob_id_1(in_rob_id_1), .rob_free(rob_free),
    .in_ready_0(in_ready_0), .in_ready_1(in_ready_1),
    .alu_issue_valid(alu_issue_valid), .lsu_issue_valid(lsu_issue_valid), .bru_issue_valid(bru_issue_valid),
    .alu_dispatch_instruction_0(alu_dispatch_instruction_0), .alu_dispatch_instruction_1(alu_dispatch_instruction_1),
    .alu_rob_id_0(alu_rob_id_0), .alu_rob_id_1(alu_rob_id_1),
    .alu_dispatch_valid_0(alu_dispatch_valid_0), .alu_dispatch_valid_1(alu_dispatch_valid_1),
    .lsu_dispatch_instruction_0(lsu_dispatch_instruction_0), .lsu_dispatch_instruction_1(lsu_dispatch_instruction_1),
    .lsu_rob_id_0(lsu_rob_id_0), .lsu_rob_id_1(lsu_rob_id_1),
    .lsu_dispatch_valid_0(lsu_dispatch_valid_0), .lsu_dispatch_valid_1(lsu_dispatch_valid_1),
    .bru_dispatch_instruction_0(bru_dispatch_instruction_0), .bru_dispatch_instruction_1(bru_dispatch_instruction_1),
    .bru_rob_id_0(bru_rob_id_0), .bru_rob_id_1(bru_rob_id_1),
    .bru_dispatch_valid_0(bru_dispatch_valid_0), .bru_dispatch_valid_1(bru_dispatch_valid_1),
    .illegal_valid(illegal_valid), .stat_dispatched(stat_dispatched), .stat_stall_cycles(stat_stall_cycles)
  );

  always #5 clk = ~clk;

  logic [2:0] d_v0, d_v1, iss_v;
  logic [RW-1:0] d_rob0 [3], d_rob1 [3];
  logic [IW-1:0] d_ins0 [3], d_ins1 [3];
  assign d_v0 = {bru_dispatch_valid_0, lsu_dispatch_valid_0, alu_dispatch_valid_0};
  assign d_v1 = {bru_dispatch_valid_1, lsu_dispatch_valid_1, alu_dispatch_valid_1};
  assign iss_v = {bru_issue_valid, lsu_issue_valid, alu_issue_valid};
  assign d_rob0[0] = alu_rob_id_0; assign d_rob0[1] = lsu_rob_id_0; assign d_rob0[2] = bru_rob_id_0;
  assign d_rob1[0] = alu_rob_id_1; assign d_rob1[1] = lsu_rob_id_1; assign d_rob1[2] = bru_rob_id_1;
  assign d_ins0[0] = alu_dispatch_instruction_0; assign d_ins0[1] = lsu_dispatch_instruction_0;
  assign d_ins0[2] = bru_dispatch_instruction_0;
  assign d_ins1[0] = alu_dispatch_instruction_1; assign d_ins1[1] = lsu_dispatch_instruction_1;
  assign d_ins1[2] = bru_dispatch_instruction_1;

  int checks = 0, errors = 0;
  int m_cred [3];
  int m_c0, m_c1;
  bit m_r0, m_r1, e_ill;
  logic [2:0] e_v0, e_v1;
  logic [RW-1:0] e_rob0, e_rob1;
  logic [IW-1:0] e_ins0, e_ins1;
  logic [31:0] m_disp, m_stall;
  logic [6:0] ops [12] = '{LOAD, STORE, BRANCH, JAL, JALR, OP, OPI, LUI, AUIPC, SYS, BAD0, BAD1};

  // RS index a class routes to: 0 ALU, 1 LSU, 2 BRU, -1 unroutable.
  function automatic int rs_of(input logic [6:0] op);
    if (op == LOAD || op == STORE) return 1;
    if (op == BRANCH || op == JAL || op == JALR) return 2;
    if (op == OP || op == OPI || op == LUI || op == AUIPC || op == SYS) return 0;
    return -1;
  endfunction

  task automatic model_reset;
    for (int c = 0; c < 3; c++) m_cred[c] = N;
    e_v0 = '0; e_v1 = '0; e_ill = 1'b0; m_disp = '0; m_stall = '0;
  endtask

  task automatic set_in(input bit v0, input bit v1, input logic [6:0] op0, input logic [6:0] op1,
                        input int rf, input logic [2:0] iss, input bit fl);
    int need;
    in_valid_0 = v0; in_valid_1 = v1;
    in_instruction_0 = {25'($urandom), op0};
    in_instruction_1 = {25'($urandom), op1};
    in_rob_id_0 = RW'($urandom);
    in_rob_id_1 = in_rob_id_0 + 1'b1;
    rob_free = (RW+1)'(rf);
    {bru_issue_valid, lsu_issue_valid, alu_issue_valid} = iss;
    flush = fl;
    m_c0 = rs_of(op0); m_c1 = rs_of(op1);
    need = (m_c1 == m_c0) ? 2 : 1;
    m_r0 = v0 && !fl && rf >= 1 && (m_c0 < 0 || m_cred[m_c0 < 0 ? 0 : m_c0] >= 1);
    m_r1 = m_r0 && v1 && rf >= 2 && (m_c1 < 0 || m_cred[m_c1 < 0 ? 0 : m_c1] >= need);
  endtask

  task automatic tick;
    @(posedge clk);
    e_v0 = '0; e_v1 = '0; e_ill = 1'b0;
    if (m_r0) begin
      if (m_c0 < 0) e_ill = 1'b1;
      else begin e_v0[m_c0] = 1'b1; m_cred[m_c0]--; end
    end
    if (m_r1) begin
      if (m_c1 < 0) e_ill = 1'b1;
      else begin e_v1[m_c1] = 1'b1; m_cred[m_c1]--; end
    end
    e_rob0 = in_rob_id_0; e_rob1 = in_rob_id_1; e_ins0 = in_instruction_0; e_ins1 = in_instruction_1;
    for (int c = 0; c < 3; c++) if (iss_v[c]) m_cred[c]++;
    if (flush) for (int c = 0; c < 3; c++) m_cred[c] = N;
    m_disp = m_disp + 32'(m_r0) + 32'(m_r1);
    if (in_valid_0 && !m_r0) m_stall = m_stall + 1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if (d_v0 !== 3'b0 || d_v1 !== 3'b0) begin
      errors++; $display("FAIL reset_valids: got %b/%b exp 000/000", d_v0, d_v1);
    end
    checks++;
    if (illegal_valid !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b exp 0", illegal_valid); end
    checks++;
    if (stat_dispatched !== 32'd0 || stat_stall_cycles !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d exp 0/0", stat_dispatched, stat_stall_cycles);
    end
  endtask

  task automatic test_basic;
    set_in(1, 1, OP, OP, 8, 3'b000, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b1 || in_ready_1 !== 1'b1) begin
      errors++; $display("FAIL basic_ready: got %b%b exp 11", in_ready_0, in_ready_1);
    end
    tick;
    checks++;
    if (d_v0 !== 3'b001 || d_v1 !== 3'b001) begin
      errors++; $display("FAIL basic_valids: got %b/%b exp 001/001", d_v0, d_v1);
    end
    checks++;
    if (alu_rob_id_0 !== e_rob0 || alu_rob_id_1 !== e_rob1) begin
      errors++; $display("FAIL basic_robid: got %0d/%0d exp %0d/%0d", alu_rob_id_0, alu_rob_id_1, e_rob0, e_rob1);
    end
  endtask

  task automatic test_credit_limit;
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, OP, OPI, 8, 3'b000, 0);
      #1 checks++;
      if (in_ready_1 !== 1'b1) begin errors++; $display("FAIL drain_alu_ready1: got %b exp 1", in_ready_1); end
      tick;
    end
    set_in(1, 0, LUI, OP, 8, 3'b000, 0);
    tick;
    set_in(1, 1, OP, OP, 8, 3'b000, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b1 || in_ready_1 !== 1'b0) begin
      errors++; $display("FAIL credit1_ready: got %b%b exp 10", in_ready_0, in_ready_1);
    end
    tick;
    checks++;
    if (d_v0 !== 3'b001 || d_v1 !== 3'b000) begin
      errors++; $display("FAIL credit1_valids: got %b/%b exp 001/000", d_v0, d_v1);
    end
    set_in(1, 0, AUIPC, OP, 8, 3'b000, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b0) begin errors++; $display("FAIL credit0_ready: got %b exp 0", in_ready_0); end
    tick;
  endtask

  task automatic test_issue_return;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, LOAD, STORE, 8, 3'b000, 0);
      tick;
    end
    set_in(1, 0, LOAD, OP, 8, 3'b010, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b0) begin errors++; $display("FAIL same_cycle_return: got %b exp 0", in_ready_0); end
    tick;
    set_in(1, 0, LOAD, OP, 8, 3'b000, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b1) begin errors++; $display("FAIL returned_credit: got %b exp 1", in_ready_0); end
    tick;
    checks++;
    if (d_v0 !== 3'b010) begin errors++; $display("FAIL load_dispatch: got %b exp 010", d_v0); end
  endtask

  task automatic test_flush;
    set_in(1, 0, JAL, OP, 8, 3'b000, 0);
    tick;
    set_in(1, 1, BRANCH, OP, 8, 3'b100, 1);
    #1 checks++;
    if (in_ready_0 !== 1'b0 || in_ready_1 !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b%b exp 00", in_ready_0, in_ready_1);
    end
    tick;
    checks++;
    if (d_v0 !== 3'b0 || d_v1 !== 3'b0 || illegal_valid !== 1'b0) begin
      errors++; $display("FAIL flush_valids: got %b/%b/%b exp 000/000/0", d_v0, d_v1, illegal_valid);
    end
    set_in(1, 1, OP, OP, 8, 3'b000, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b1 || in_ready_1 !== 1'b1) begin
      errors++; $display("FAIL flush_refill: got %b%b exp 11", in_ready_0, in_ready_1);
    end
    tick;
  endtask

  task automatic test_partial_rob;
    set_in(1, 1, BRANCH, STORE, 1, 3'b000, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b1 || in_ready_1 !== 1'b0) begin
      errors++; $display("FAIL rob1_ready: got %b%b exp 10", in_ready_0, in_ready_1);
    end
    tick;
    checks++;
    if (bru_dispatch_valid_0 !== 1'b1 || lsu_dispatch_valid_1 !== 1'b0) begin
      errors++; $display("FAIL rob1_valids: got bru0=%b lsu1=%b exp 1/0", bru_dispatch_valid_0, lsu_dispatch_valid_1);
    end
  endtask

  task automatic test_illegal;
    set_in(1, 1, BAD0, OP, 8, 3'b000, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b1 || in_ready_1 !== 1'b1) begin
      errors++; $display("FAIL illegal_ready: got %b%b exp 11", in_ready_0, in_ready_1);
    end
    tick;
    checks++;
    if (illegal_valid !== 1'b1 || d_v1 !== 3'b001 || d_v0 !== 3'b000) begin
      errors++; $display("FAIL illegal_route: got ill=%b v0=%b v1=%b exp 1/000/001", illegal_valid, d_v0, d_v1);
    end
    set_in(0, 0, OP, OP, 8, 3'b000, 0);
    tick;
    checks++;
    if (illegal_valid !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %b exp 0", illegal_valid); end
  endtask

  task automatic test_random;
    bit v0, fl;
    logic [2:0] iss;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v0 = $urandom_range(0, 3) != 0;
      for (int c = 0; c < 3; c++) iss[c] = m_cred[c] < N && $urandom_range(0, 2) == 0;
      fl = $urandom_range(0, 29) == 0;
      set_in(v0, v0 && $urandom_range(0, 1) == 1, ops[$urandom_range(0, 11)], ops[$urandom_range(0, 11)],
             $urandom_range(0, 8), iss, fl);
      #1 checks++;
      if (in_ready_0 !== m_r0 || in_ready_1 !== m_r1) begin
        errors++; $display("FAIL rnd_ready cyc %0d: got %b%b exp %b%b", cyc, in_ready_0, in_ready_1, m_r0, m_r1);
      end
      tick;
      checks++;
      if (d_v0 !== e_v0 || d_v1 !== e_v1 || illegal_valid !== e_ill) begin
        errors++; $display("FAIL rnd_valids cyc %0d: got %b/%b/%b exp %b/%b/%b", cyc, d_v0, d_v1, illegal_valid,
                           e_v0, e_v1, e_ill);
      end
      for (int c = 0; c < 3; c++) begin
        if (e_v0[c]) begin
          checks++;
          if (d_rob0[c] !== e_rob0 || d_ins0[c] !== e_ins0) begin
            errors++; $display("FAIL rnd_payload0 rs %0d: got %0d/%h exp %0d/%h", c, d_rob0[c], d_ins0[c], e_rob0, e_ins0);
          end
        end
        if (e_v1[c]) begin
          checks++;
          if (d_rob1[c] !== e_rob1 || d_ins1[c] !== e_ins1) begin
            errors++; $display("FAIL rnd_payload1 rs %0d: got %0d/%h exp %0d/%h", c, d_rob1[c], d_ins1[c], e_rob1, e_ins1);
          end
        end
      end
      checks++;
      if (stat_dispatched !== (STATS ? m_disp : 32'd0) || stat_stall_cycles !== (STATS ? m_stall : 32'd0)) begin
        errors++; $display("FAIL rnd_stats: got %0d/%0d exp %0d/%0d", stat_dispatched, stat_stall_cycles,
                           STATS ? m_disp : 32'd0, STATS ? m_stall : 32'd0);
      end
    end
  endtask

  task automatic test_async_reset;
    set_in(0, 0, OP, OP, 8, 3'b000, 1);
    tick;
    set_in(1, 1, OP, OP, 8, 3'b000, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 checks++;
    if (d_v0 !== 3'b0 || d_v1 !== 3'b0 || stat_dispatched !== 32'd0) begin
      errors++; $display("FAIL async_reset: got %b/%b/%0d exp 000/000/0", d_v0, d_v1, stat_dispatched);
    end
    model_reset;
    set_in(0, 0, OP, OP, 8, 3'b000, 0);
    @(negedge clk);
    rst = 1'b1;
    set_in(1, 1, SYS, OPI, 8, 3'b000, 0);
    #1 checks++;
    if (in_ready_0 !== 1'b1 || in_ready_1 !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %b%b exp 11", in_ready_0, in_ready_1);
    end
    tick;
    checks++;
    if (d_v0 !== 3'b001 || d_v1 !== 3'b001) begin
      errors++; $display("FAIL post_reset_dispatch: got %b/%b exp 001/001", d_v0, d_v1);
    end
  endtask

  initial begin
    rst = 1'b0;
    model_reset;
    set_in(0, 0, OP, OP, 0, 3'b000, 0);
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    test_basic;
    test_credit_limit;
    test_issue_return;
    test_flush;
    test_partial_rob;
    test_illegal;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
